// File: rtl/pcpi_coproc_mux.sv
// Routes one PCPI request from the core to up to NPORTS coprocessors. The lowest-index
// port that claims the instruction owns it; if no port claims it in time, the mux flags
// it as illegal.
module pcpi_coproc_mux #(
  parameter int NPORTS  = 2,
  parameter int TIMEOUT = 16
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   cpu_valid,
  input  logic [31:0]            cpu_insn,
  input  logic [31:0]            cpu_rs1,
  input  logic [31:0]            cpu_rs2,
  output logic                   cpu_wr,
  output logic                   cpu_wait,
  output logic                   cpu_ready,
  output logic                   cpu_illegal,
  output logic [31:0]            cpu_rd,
  output logic [NPORTS-1:0]      cp_valid,
  output logic [31:0]            cp_insn,
  output logic [31:0]            cp_rs1,
  output logic [31:0]            cp_rs2,
  input  logic [NPORTS-1:0]      cp_wr,
  input  logic [NPORTS-1:0]      cp_wait,
  input  logic [NPORTS-1:0]      cp_ready,
  input  logic [32*NPORTS-1:0]   cp_rd
);

  localparam int OW = (NPORTS > 1) ? $clog2(NPORTS) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, BUSY, DONE} state_e;

  state_e              state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [OW-1:0]       owner_q, owner_d;
  logic [NPORTS-1:0]   cp_valid_q, cp_valid_d;
  logic [31:0]         cp_insn_q, cp_insn_d;
  logic [31:0]         cp_rs1_q, cp_rs1_d;
  logic [31:0]         cp_rs2_q, cp_rs2_d;
  logic [31:0]         cpu_rd_q, cpu_rd_d;
  logic                cpu_wr_q, cpu_wr_d;
  logic                cpu_wait_q, cpu_wait_d;
  logic                cpu_ready_q, cpu_ready_d;
  logic                cpu_illegal_q, cpu_illegal_d;

  logic [31:0]         cp_rd_arr [NPORTS];
  logic                claim_any;
  logic [OW-1:0]       claim_idx;
  logic [OW-1:0]       resp_idx;
  logic                respond;

  for (genvar g = 0; g < NPORTS; g++) begin : g_rd_split
    assign cp_rd_arr[g] = cp_rd[32*g +: 32];
  end

  // Descending scan so the lowest claiming index is the one left standing.
  always_comb begin
    claim_any = 1'b0;
    claim_idx = '0;
    for (int k = NPORTS - 1; k >= 0; k--) begin
      if (cp_wait[k] || cp_ready[k]) begin
        claim_any = 1'b1;
        claim_idx = OW'(k);
      end
    end
  end

  // In ISSUE there is no owner yet, so the response comes from the port claiming right now.
  assign resp_idx = (state_q == ISSUE) ? claim_idx : owner_q;

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    owner_d       = owner_q;
    cp_valid_d    = cp_valid_q;
    cp_insn_d     = cp_insn_q;
    cp_rs1_d      = cp_rs1_q;
    cp_rs2_d      = cp_rs2_q;
    cpu_rd_d      = cpu_rd_q;
    cpu_wait_d    = cpu_wait_q;
    cpu_wr_d      = 1'b0;
    cpu_ready_d   = 1'b0;
    cpu_illegal_d = 1'b0;
    respond       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cpu_valid) begin
          cp_insn_d  = cpu_insn;
          cp_rs1_d   = cpu_rs1;
          cp_rs2_d   = cpu_rs2;
          cp_valid_d = '1;
          cnt_d      = '0;
          owner_d    = '0;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        if (!cpu_valid) begin
          cp_valid_d = '0;
          cpu_wait_d = 1'b0;
          state_d    = IDLE;
        end else if (claim_any) begin
          owner_d = claim_idx;
          if (cp_ready[claim_idx]) begin
            respond = 1'b1;
          end else begin
            cpu_wait_d = 1'b1;
            state_d    = BUSY;
          end
        end else if (cnt_q == 8'(TIMEOUT - 1)) begin
          cpu_illegal_d = 1'b1;
          cp_valid_d    = '0;
          state_d       = DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      BUSY: begin
        if (!cpu_valid) begin
          cp_valid_d = '0;
          cpu_wait_d = 1'b0;
          state_d    = IDLE;
        end else if (cp_ready[owner_q]) begin
          respond = 1'b1;
        end
      end
      DONE: begin
        if (!cpu_valid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (respond) begin
      cpu_ready_d = 1'b1;
      cpu_wr_d    = cp_wr[resp_idx];
      cpu_rd_d    = cp_rd_arr[resp_idx];
      cpu_wait_d  = 1'b0;
      cp_valid_d  = '0;
      state_d     = DONE;
    end
  end

  // NOTE: synchronous reset also clears the datapath registers, so a response that
  // arrives in the reset cycle is simply overwritten.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      owner_q       <= '0;
      cp_valid_q    <= '0;
      cp_insn_q     <= '0;
      cp_rs1_q      <= '0;
      cp_rs2_q      <= '0;
      cpu_rd_q      <= '0;
      cpu_wr_q      <= 1'b0;
      cpu_wait_q    <= 1'b0;
      cpu_ready_q   <= 1'b0;
      cpu_illegal_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      owner_q       <= owner_d;
      cp_valid_q    <= cp_valid_d;
      cp_insn_q     <= cp_insn_d;
      cp_rs1_q      <= cp_rs1_d;
      cp_rs2_q      <= cp_rs2_d;
      cpu_rd_q      <= cpu_rd_d;
      cpu_wr_q      <= cpu_wr_d;
      cpu_wait_q    <= cpu_wait_d;
      cpu_ready_q   <= cpu_ready_d;
      cpu_illegal_q <= cpu_illegal_d;
    end
  end

  assign cp_valid    = cp_valid_q;
  assign cp_insn     = cp_insn_q;
  assign cp_rs1      = cp_rs1_q;
  assign cp_rs2      = cp_rs2_q;
  assign cpu_rd      = cpu_rd_q;
  assign cpu_wr      = cpu_wr_q;
  assign cpu_wait    = cpu_wait_q;
  assign cpu_ready   = cpu_ready_q;
  assign cpu_illegal = cpu_illegal_q;

endmodule

// File: doc/pcpi_coproc_mux.md
PCPI_COPROC_MUX -- requirements
Module: pcpi_coproc_mux

Interface
REQ-001 SHALL have parameter NPORTS, default 2, meaning number of coprocessor ports (1..8).
REQ-002 SHALL have parameter TIMEOUT, default 16, meaning cycles allowed for a coprocessor to claim an instruction (range 4..255).
REQ-003 SHALL have port clk  input  1  clock; all state updates on the rising edge.
REQ-004 SHALL have port resetn  input  1  reset, synchronous, active-low.
REQ-005 SHALL have ports cpu_valid  input  1; cpu_insn, cpu_rs1, cpu_rs2  input  32 each  core-side request.
REQ-006 SHALL have ports cpu_wr, cpu_wait, cpu_ready, cpu_illegal  output  1 each; cpu_rd  output  32  core-side response.
REQ-007 SHALL have ports cp_valid  output  NPORTS; cp_insn, cp_rs1, cp_rs2  output  32 each  broadcast to coprocessors.
REQ-008 SHALL have ports cp_wr, cp_wait, cp_ready  input  NPORTS; cp_rd  input  32*NPORTS, port k in bits [32k+31:32k].

Function
REQ-009 SHALL implement states IDLE, ISSUE, BUSY, DONE, all outputs registered.
REQ-010 IDLE: on cpu_valid=1 SHALL latch cpu_insn/rs1/rs2 into cp_insn/rs1/rs2, set all cp_valid bits to 1, clear timeout counter, go ISSUE (cp_valid visible 1 cycle after cpu_valid).
REQ-011 ISSUE: counter increments each cycle; the first cycle any cp_wait[k] or cp_ready[k] is 1, the lowest such k SHALL become owner and cpu_wait SHALL be 1 from the next cycle.
REQ-012 ISSUE, owner claims with cp_ready[owner]=1 in the same cycle: SHALL go directly to the response action of REQ-014, skipping BUSY.
REQ-013 ISSUE, counter reaches TIMEOUT-1 with no claim: SHALL pulse cpu_illegal for exactly 1 cycle, clear cp_valid, go DONE; cpu_ready and cpu_wr SHALL stay 0.
REQ-014 BUSY: on cp_ready[owner]=1 SHALL, next cycle, pulse cpu_ready=1 for 1 cycle, set cpu_wr=cp_wr[owner], cpu_rd=cp_rd[owner], clear cpu_wait and cp_valid, go DONE.
REQ-015 cp_wait/cp_ready/cp_wr/cp_rd from non-owner ports SHALL be ignored; simultaneous claims resolve to lowest index.
REQ-016 BUSY has no timeout; owner may hold cp_wait indefinitely.
REQ-017 DONE: SHALL stay until cpu_valid=0, then go IDLE; a new request is accepted no earlier than the cycle after cpu_valid is seen low.
REQ-018 Abort: cpu_valid=0 in ISSUE or BUSY SHALL clear cp_valid and cpu_wait next cycle and go IDLE with no response.
REQ-019 cpu_rd SHALL hold its last value when cpu_ready=0; cpu_wr SHALL be 0 whenever cpu_ready=0.
REQ-020 With owner asserting cp_ready at cycle n, cpu_ready SHALL assert at cycle n+1 (1-cycle added latency).

Reset
REQ-021 resetn=0 at a clock edge SHALL force IDLE, cp_valid=0, cpu_wr=0, cpu_wait=0, cpu_ready=0, cpu_illegal=0, counter=0, owner cleared, from any state.
REQ-022 cpu_rd, cp_insn, cp_rs1, cp_rs2 SHALL be reset to 0.
REQ-023 A coprocessor response arriving in the same cycle as resetn=0 SHALL be dropped.

Verification
REQ-024 MUL insn 0x02B50533, rs1=7, rs2=6, multiplier on port 0 -> cp_valid[0] 1 cycle after cpu_valid, cpu_wait high while busy, single cpu_ready pulse with cpu_wr=1, cpu_rd=42.
REQ-025 Unclaimed insn 0x0000000B, TIMEOUT=16 -> cpu_illegal pulses 16 cycles after cp_valid rises, cpu_ready never asserts, state returns IDLE after cpu_valid drops.
REQ-026 Ports 0 and 1 assert cp_ready in the same cycle with rd 0x11111111 / 0x22222222 -> cpu_rd=0x11111111, exactly one cpu_ready pulse.
REQ-027 cpu_valid dropped 3 cycles into a MULH -> cp_valid and cpu_wait 0 next cycle, no cpu_ready; following MUL 3*5 returns cpu_rd=15.
REQ-028 resetn=0 for 1 cycle in BUSY -> all outputs at reset values next cycle; later MULHU 0xFFFFFFFF*0xFFFFFFFF returns cpu_rd=0xFFFFFFFE.
